// File: rtl/sequence_player.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sequence_player: plays stored Simon colours from sequence_rom onto the LEDs |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sequence_player #(
  parameter int DEPTH      = 10,
  parameter int AW         = 4,
  parameter int DW         = 2,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CW         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW-1:0]        len,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        rd_data,
  output logic [(2**DW)-1:0]   led_onehot,
  output logic                 busy,
  output logic                 done
);

  localparam int            LW         = 2**DW;
  localparam logic [AW-1:0] C_DEPTH    = AW'(DEPTH);
  localparam logic [AW-1:0] C_ONE_A    = AW'(1);
  localparam logic [CW-1:0] C_ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] C_OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] C_LED_ONE  = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_len_q;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_addr;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_led;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] w_len_clamped;

  assign w_len_clamped = (len > C_DEPTH) ? C_DEPTH : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len_q   <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // abort also blocks a simultaneous start while idle
      if (abort) begin
        r_state <= S_IDLE;
        r_led   <= '0;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len_q <= w_len_clamped;
              if (w_len_clamped == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_idx     <= '0;
                r_rd_addr <= '0;
                r_busy    <= 1'b1;
                r_state   <= S_FETCH;
              end
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            r_led   <= C_LED_ONE << rd_data;
            r_cnt   <= '0;
            r_state <= S_SHOW;
          end
          S_SHOW: begin
            if (r_cnt == C_ON_LAST) begin
              r_led   <= '0;
              r_cnt   <= '0;
              r_state <= S_GAP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_GAP: begin
            if (r_cnt == C_OFF_LAST) begin
              r_cnt <= '0;
              if (r_idx == r_len_q - C_ONE_A) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_idx     <= r_idx + C_ONE_A;
                r_rd_addr <= r_idx + C_ONE_A;
                r_state   <= S_FETCH;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_addr    = r_rd_addr;
  assign led_onehot = r_led;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
